// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch sequencer: load-use stalls, branch flushes and
// the mult/div start/wait handshake with a stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int CNT_W      = 16,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      fd_insn,
  input  logic [31:0]      dx_insn,
  input  logic             branch_taken,
  input  logic             md_ready,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             xm_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic             xm_bubble,
  output logic             md_start,
  output logic             md_error,
  output logic [CNT_W-1:0] stall_count
);

  localparam int TW = $clog2(MD_TIMEOUT + 1);

  localparam logic [4:0] OP_R   = 5'b00000;
  localparam logic [4:0] OP_LW  = 5'b01000;
  localparam logic [4:0] OP_SW  = 5'b00111;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_JR  = 5'b00100;

  typedef enum logic [1:0] {
    IDLE,
    MD_WAIT,
    MD_DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          md_pass;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_alu;
  logic       dx_md, fd_uses_rd, load_use;
  logic       br_act, md_stall, lu_act;
  logic       unused_bits;

  assign fd_op  = fd_insn[31:27];
  assign fd_rd  = fd_insn[26:22];
  assign fd_rs  = fd_insn[21:17];
  assign fd_rt  = fd_insn[16:12];
  assign dx_op  = dx_insn[31:27];
  assign dx_rd  = dx_insn[26:22];
  assign dx_alu = dx_insn[6:2];

  assign unused_bits = ^{fd_insn[11:0], dx_insn[21:7], dx_insn[1:0]};

  assign dx_md = (dx_op == OP_R) &&
                 (dx_alu == 5'b00110 || dx_alu == 5'b00111);

  assign fd_uses_rd = (fd_op == OP_SW) || (fd_op == OP_BNE) ||
                      (fd_op == OP_BLT) || (fd_op == OP_JR);

  assign load_use = (dx_op == OP_LW) && (dx_rd != 5'd0) &&
                    ((dx_rd == fd_rs) ||
                     ((fd_op == OP_R) && (dx_rd == fd_rt)) ||
                     (fd_uses_rd && (dx_rd == fd_rd)));

  // The cycle after a timeout lets the stuck mult/div leave D/X
  // instead of restarting the unit on it.
  assign br_act   = branch_taken && (state != MD_WAIT);
  assign md_stall = !br_act &&
                    ((state == MD_WAIT) ||
                     ((state == IDLE) && dx_md && !md_pass));
  assign lu_act   = !br_act && !md_stall && load_use;

  always_comb begin
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    dx_en     = 1'b1;
    xm_en     = 1'b1;
    mw_en     = 1'b1;
    fd_flush  = 1'b0;
    dx_flush  = 1'b0;
    xm_bubble = 1'b0;
    md_start  = 1'b0;
    if (!reset) begin
      if (br_act) begin
        fd_flush = 1'b1;
        dx_flush = 1'b1;
      end else if (md_stall) begin
        pc_en     = 1'b0;
        fd_en     = 1'b0;
        dx_en     = 1'b0;
        xm_bubble = 1'b1;
        md_start  = (state == IDLE);
      end else if (lu_act) begin
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        dx_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      md_pass     <= 1'b0;
      md_error    <= 1'b0;
      stall_count <= '0;
    end else begin
      md_pass <= 1'b0;
      if (!pc_en && stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + 1'b1;
      unique case (state)
        IDLE: begin
          if (md_start) begin
            state <= MD_WAIT;
            timer <= '0;
          end
        end
        MD_WAIT: begin
          if (md_ready) begin
            state <= MD_DONE;
          end else if (timer == TW'(MD_TIMEOUT - 1)) begin
            state    <= IDLE;
            md_error <= 1'b1;
            md_pass  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        MD_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
